sdfa_setup_loader: RTL and testbench

// - Upstream configuration stage for sdfa_master. Holds the per-block setup table (BLOCK_ID, blocks-per-layer, read-block mask).
// - A host loads the table through a simple write port.
// - When sdfa_master raises setup_request, the block streams the table out, one entry per cycle, qualified by setup_valid.
// - The stream drives the master's BLOCK_ID_INPUT, BLOCK_NUM_PER_LAYER_INPUT and READ_BLOCK_INPUT ports.

---
 rtl/sdfa_setup_loader.sv | 145 ++++++++++++++
 tb/tb_sdfa_setup_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdfa_setup_loader.sv
// Setup table for sdfa_master: loaded by the host through a write port and
// streamed out one entry per cycle on each rising edge of setup_request.
module sdfa_setup_loader #(
  parameter int unsigned BLOCK_NUM      = 8,
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned BLOCK_ID_WIDTH = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]     cfg_wr_idx,
  input  logic [1:0]                cfg_wr_sel,
  input  logic [BLOCK_ID_WIDTH-1:0] cfg_wr_data,
  input  logic                      cfg_commit,
  output logic                      cfg_armed,
  input  logic                      setup_request,
  output logic                      setup_valid,
  output logic [BLOCK_ID_WIDTH-1:0] BLOCK_ID_INPUT,
  output logic [ADDR_WIDTH-1:0]     BLOCK_NUM_PER_LAYER_INPUT,
  output logic [BLOCK_NUM-1:0]      READ_BLOCK_INPUT,
  output logic                      setup_done,
  output logic                      setup_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(BLOCK_NUM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                    state;
  logic [BLOCK_ID_WIDTH-1:0] id_tab  [BLOCK_NUM];
  logic [ADDR_WIDTH-1:0]     num_tab [BLOCK_NUM];
  logic [BLOCK_NUM-1:0]      rd_tab  [BLOCK_NUM];

  logic                      req_q;
  logic [ADDR_WIDTH-1:0]     idx;
  logic [ADDR_WIDTH-1:0]     idx_nxt_c;
  logic                      req_edge_c;
  logic                      wr_acc_c;
  logic                      start_c;
  logic [BLOCK_ID_WIDTH-1:0] id0_c;
  logic [ADDR_WIDTH-1:0]     num0_c;
  logic [BLOCK_NUM-1:0]      rd0_c;

  assign req_edge_c = setup_request & ~req_q;
  assign wr_acc_c   = cfg_wr_en && (state != STREAM) && (cfg_wr_sel != 2'd3);
  assign start_c    = req_edge_c && (state != STREAM) &&
                      (cfg_commit || ((state == ARMED) && !wr_acc_c));
  assign idx_nxt_c  = idx + ADDR_WIDTH'(1);

  // Entry 0 with a same-cycle write forwarded, so write+commit+request streams the new value
  always_comb begin
    id0_c  = id_tab[0];
    num0_c = num_tab[0];
    rd0_c  = rd_tab[0];
    if (wr_acc_c && (cfg_wr_idx == '0)) begin
      case (cfg_wr_sel)
        2'd0:    id0_c  = cfg_wr_data;
        2'd1:    num0_c = cfg_wr_data[ADDR_WIDTH-1:0];
        2'd2:    rd0_c  = cfg_wr_data[BLOCK_NUM-1:0];
        default: ;
      endcase
    end
  end

  // Table storage; frozen while streaming
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_NUM; i++) begin
        id_tab[i]  <= '0;
        num_tab[i] <= '0;
        rd_tab[i]  <= '0;
      end
    end else if (wr_acc_c) begin
      case (cfg_wr_sel)
        2'd0:    id_tab[cfg_wr_idx]  <= cfg_wr_data;
        2'd1:    num_tab[cfg_wr_idx] <= cfg_wr_data[ADDR_WIDTH-1:0];
        2'd2:    rd_tab[cfg_wr_idx]  <= cfg_wr_data[BLOCK_NUM-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                     <= IDLE;
      req_q                     <= 1'b0;
      idx                       <= '0;
      cfg_armed                 <= 1'b0;
      setup_valid               <= 1'b0;
      BLOCK_ID_INPUT            <= '0;
      BLOCK_NUM_PER_LAYER_INPUT <= '0;
      READ_BLOCK_INPUT          <= '0;
      setup_done                <= 1'b0;
      setup_err                 <= 1'b0;
    end else begin
      req_q      <= setup_request;
      setup_done <= 1'b0;
      setup_err  <= 1'b0;
      case (state)
        STREAM: begin
          if (idx == LAST_IDX) begin
            state                     <= ARMED;
            idx                       <= '0;
            cfg_armed                 <= 1'b1;
            setup_valid               <= 1'b0;
            BLOCK_ID_INPUT            <= '0;
            BLOCK_NUM_PER_LAYER_INPUT <= '0;
            READ_BLOCK_INPUT          <= '0;
            setup_done                <= 1'b1;
          end else begin
            idx                       <= idx_nxt_c;
            BLOCK_ID_INPUT            <= id_tab[idx_nxt_c];
            BLOCK_NUM_PER_LAYER_INPUT <= num_tab[idx_nxt_c];
            READ_BLOCK_INPUT          <= rd_tab[idx_nxt_c];
          end
        end
        default: begin
          if (start_c) begin
            state                     <= STREAM;
            idx                       <= '0;
            cfg_armed                 <= 1'b0;
            setup_valid               <= 1'b1;
            BLOCK_ID_INPUT            <= id0_c;
            BLOCK_NUM_PER_LAYER_INPUT <= num0_c;
            READ_BLOCK_INPUT          <= rd0_c;
          end else begin
            if (req_edge_c) setup_err <= 1'b1;
            if (cfg_commit) begin
              state     <= ARMED;
              cfg_armed <= 1'b1;
            end else if (wr_acc_c) begin
              state     <= IDLE;
              cfg_armed <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdfa_setup_loader.sv
// Bench for sdfa_setup_loader: directed vector table, corner-case sequences and
// random traffic, all checked against a queue-based model of the setup stream.
module tb_sdfa_setup_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr_en;
  logic [2:0]  cfg_wr_idx;
  logic [1:0]  cfg_wr_sel;
  logic [32:0] cfg_wr_data;
  logic        cfg_commit;
  logic        cfg_armed;
  logic        setup_request;
  logic        setup_valid;
  logic [32:0] BLOCK_ID_INPUT;
  logic [2:0]  BLOCK_NUM_PER_LAYER_INPUT;
  logic [7:0]  READ_BLOCK_INPUT;
  logic        setup_done;
  logic        setup_err;

  sdfa_setup_loader #(.BLOCK_NUM(8), .ADDR_WIDTH(3), .BLOCK_ID_WIDTH(33)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_sel(cfg_wr_sel),
    .cfg_wr_data(cfg_wr_data), .cfg_commit(cfg_commit), .cfg_armed(cfg_armed),
    .setup_request(setup_request), .setup_valid(setup_valid),
    .BLOCK_ID_INPUT(BLOCK_ID_INPUT), .BLOCK_NUM_PER_LAYER_INPUT(BLOCK_NUM_PER_LAYER_INPUT),
    .READ_BLOCK_INPUT(READ_BLOCK_INPUT), .setup_done(setup_done), .setup_err(setup_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: table contents plus a queue of entries still to be streamed
  typedef struct packed {
    logic [32:0] id;
    logic [2:0]  num;
    logic [7:0]  rd;
  } ent_t;

  ent_t m_tab [8];
  ent_t m_q [$];
  ent_t m_cur;
  bit   m_valid, m_armed, m_done, m_err, m_prevreq;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_tab[k] = '0;
    m_q.delete();
    m_cur = '0; m_valid = 0; m_armed = 0; m_done = 0; m_err = 0; m_prevreq = 0;
  endtask

  task automatic model_step();
    bit edge_s, wr_ok;
    edge_s    = setup_request && !m_prevreq;
    m_prevreq = setup_request;
    m_done = 0;
    m_err  = 0;
    if (m_valid) begin
      if (m_q.size() == 0) begin
        m_valid = 0; m_done = 1; m_armed = 1;
      end else begin
        m_cur = m_q.pop_front();
      end
    end else begin
      wr_ok = cfg_wr_en && (cfg_wr_sel != 2'd3);
      if (wr_ok) begin
        if (cfg_wr_sel == 2'd0) m_tab[cfg_wr_idx].id  = cfg_wr_data;
        if (cfg_wr_sel == 2'd1) m_tab[cfg_wr_idx].num = cfg_wr_data[2:0];
        if (cfg_wr_sel == 2'd2) m_tab[cfg_wr_idx].rd  = cfg_wr_data[7:0];
      end
      if (edge_s && (cfg_commit || (m_armed && !wr_ok))) begin
        for (int k = 0; k < 8; k++) m_q.push_back(m_tab[k]);
        m_cur   = m_q.pop_front();
        m_valid = 1;
        m_armed = 0;
      end else begin
        if (edge_s) m_err = 1;
        if (cfg_commit) m_armed = 1;
        else if (wr_ok) m_armed = 0;
      end
    end
  endtask

  task automatic compare_all();
    ent_t e;
    e = m_valid ? m_cur : '0;
    chk("setup_valid", 64'(setup_valid), 64'(m_valid));
    chk("BLOCK_ID_INPUT", 64'(BLOCK_ID_INPUT), 64'(e.id));
    chk("BLOCK_NUM_PER_LAYER_INPUT", 64'(BLOCK_NUM_PER_LAYER_INPUT), 64'(e.num));
    chk("READ_BLOCK_INPUT", 64'(READ_BLOCK_INPUT), 64'(e.rd));
    chk("setup_done", 64'(setup_done), 64'(m_done));
    chk("setup_err", 64'(setup_err), 64'(m_err));
    chk("cfg_armed", 64'(cfg_armed), 64'(m_armed));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    cfg_wr_en = 0; cfg_wr_idx = '0; cfg_wr_sel = '0; cfg_wr_data = '0;
    cfg_commit = 0; setup_request = 0;
  endtask

  task automatic wr(input int idx, input int sel, input logic [32:0] data);
    cfg_wr_en = 1; cfg_wr_idx = 3'(idx); cfg_wr_sel = 2'(sel); cfg_wr_data = data;
    tick();
    cfg_wr_en = 0;
  endtask

  // Drives request high for 'hold' cycles over 'total' cycles; counts valid cycles and done position
  task automatic stream_probe(input int hold, input int total, output int nv, output int dn);
    nv = 0; dn = 0;
    for (int c = 1; c <= total; c++) begin
      setup_request = (c <= hold);
      tick();
      if (setup_valid) nv++;
      if (setup_done) dn = c;
    end
    setup_request = 0;
  endtask

  typedef struct {
    logic        wr_en;
    logic [2:0]  widx;
    logic [1:0]  sel;
    logic [32:0] data;
    logic        commit;
    logic        req;
    logic        e_valid, e_armed, e_err, e_done;
    logic [32:0] e_id;
  } vec_t;

  function automatic vec_t mk(int w, int wi, int s, longint d, int c, int r,
                              int ev, int ea, int ee, int ed, longint eid);
    vec_t v;
    v.wr_en = 1'(w); v.widx = 3'(wi); v.sel = 2'(s); v.data = 33'(d);
    v.commit = 1'(c); v.req = 1'(r);
    v.e_valid = 1'(ev); v.e_armed = 1'(ea); v.e_err = 1'(ee); v.e_done = 1'(ed);
    v.e_id = 33'(eid);
    return v;
  endfunction

  vec_t        vt [26];
  logic [32:0] ld_id [8];
  int          nv, dn;
  logic        nreq;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    #12;
    chk("reset setup_valid", 64'(setup_valid), 64'(0));
    chk("reset cfg_armed", 64'(cfg_armed), 64'(0));
    chk("reset BLOCK_ID_INPUT", 64'(BLOCK_ID_INPUT), 64'(0));
    compare_all();
    rst = 0;

    vt[0] = mk(0,0,0,0,0,1, 0,0,1,0,0);
    vt[1] = mk(0,0,0,0,0,0, 0,0,0,0,0);
    vt[2] = mk(1,0,0,5,0,0, 0,0,0,0,0);
    vt[3] = mk(0,0,0,0,1,0, 0,1,0,0,0);
    vt[4] = mk(1,2,1,3,0,0, 0,0,0,0,0);
    vt[5] = mk(0,0,0,0,0,1, 0,0,1,0,0);
    vt[6] = mk(0,0,0,0,1,0, 0,1,0,0,0);
    vt[7] = mk(0,0,0,0,0,1, 1,0,0,0,5);
    vt[8] = mk(0,0,0,0,0,1, 1,0,0,0,0);
    for (int i = 9; i <= 14; i++) vt[i] = mk(0,0,0,0,0,0, 1,0,0,0,0);
    vt[15] = mk(0,0,0,0,0,0, 0,1,0,1,0);
    vt[16] = mk(0,0,0,0,0,0, 0,1,0,0,0);
    vt[17] = mk(0,0,0,0,0,1, 1,0,0,0,5);
    for (int i = 18; i <= 24; i++) vt[i] = mk(0,0,0,0,0,0, 1,0,0,0,0);
    vt[25] = mk(0,0,0,0,0,0, 0,1,0,1,0);

    for (int i = 0; i < 26; i++) begin
      cfg_wr_en = vt[i].wr_en; cfg_wr_idx = vt[i].widx; cfg_wr_sel = vt[i].sel;
      cfg_wr_data = vt[i].data; cfg_commit = vt[i].commit; setup_request = vt[i].req;
      tick();
      chk($sformatf("vec%0d valid", i), 64'(setup_valid), 64'(vt[i].e_valid));
      chk($sformatf("vec%0d armed", i), 64'(cfg_armed), 64'(vt[i].e_armed));
      chk($sformatf("vec%0d err", i), 64'(setup_err), 64'(vt[i].e_err));
      chk($sformatf("vec%0d done", i), 64'(setup_done), 64'(vt[i].e_done));
      chk($sformatf("vec%0d id", i), 64'(BLOCK_ID_INPUT), 64'(vt[i].e_id));
    end
    idle_inputs();

    // Full table load, commit, single pulse
    for (int k = 0; k < 8; k++) begin
      ld_id[k] = (k == 0) ? 33'h0_3FC3_0C31 : 33'({1'($urandom_range(0, 1)), $urandom});
      wr(k, 0, ld_id[k]);
      wr(k, 1, (k == 0) ? 33'd4 : 33'($urandom_range(0, 7)));
      wr(k, 2, (k == 4 || k == 5) ? 33'h03 : 33'h00);
    end
    cfg_commit = 1; tick(); cfg_commit = 0;
    chk("armed after commit", 64'(cfg_armed), 64'(1));
    stream_probe(1, 12, nv, dn);
    chk("pulse valid cycles", 64'(nv), 64'(8));
    chk("pulse done cycle", 64'(dn), 64'(9));

    // Held request streams once; a later pulse re-streams the same table
    stream_probe(20, 24, nv, dn);
    chk("held valid cycles", 64'(nv), 64'(8));
    chk("held done cycle", 64'(dn), 64'(9));
    stream_probe(1, 12, nv, dn);
    chk("restream valid cycles", 64'(nv), 64'(8));

    // Writes during the stream are ignored
    for (int c = 1; c <= 12; c++) begin
      setup_request = (c == 1);
      cfg_wr_en = (c >= 3 && c <= 5); cfg_wr_idx = 3'd3; cfg_wr_sel = 2'd0; cfg_wr_data = ~ld_id[3];
      tick();
    end
    idle_inputs();
    chk("armed after ignored writes", 64'(cfg_armed), 64'(1));
    for (int c = 1; c <= 11; c++) begin
      setup_request = (c == 1);
      tick();
      if (c == 4) chk("entry3 retained", 64'(BLOCK_ID_INPUT), 64'(ld_id[3]));
    end
    setup_request = 0;

    // Write + commit + request edge in IDLE: the write is included in the stream
    wr(1, 2, 33'h5A);
    chk("idle after write", 64'(cfg_armed), 64'(0));
    cfg_wr_en = 1; cfg_wr_idx = 3'd0; cfg_wr_sel = 2'd0; cfg_wr_data = 33'h1_2345_6789;
    cfg_commit = 1; setup_request = 1;
    tick();
    idle_inputs();
    chk("commit+edge valid", 64'(setup_valid), 64'(1));
    chk("commit+edge id", 64'(BLOCK_ID_INPUT), 64'(33'h1_2345_6789));
    chk("commit+edge err", 64'(setup_err), 64'(0));
    for (int c = 0; c < 10; c++) tick();

    // Async reset on stream cycle 3
    setup_request = 1; tick(); setup_request = 0; tick(); tick();
    chk("stream before reset", 64'(setup_valid), 64'(1));
    #2 rst = 1;
    #1;
    chk("rst valid", 64'(setup_valid), 64'(0));
    chk("rst id", 64'(BLOCK_ID_INPUT), 64'(0));
    chk("rst num", 64'(BLOCK_NUM_PER_LAYER_INPUT), 64'(0));
    chk("rst rd", 64'(READ_BLOCK_INPUT), 64'(0));
    chk("rst armed", 64'(cfg_armed), 64'(0));
    chk("rst done", 64'(setup_done), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 0;
    setup_request = 1; tick();
    chk("post-reset err", 64'(setup_err), 64'(1));
    chk("post-reset no stream", 64'(setup_valid), 64'(0));
    setup_request = 0; tick();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      cfg_wr_en   = ($urandom_range(0, 3) == 0);
      cfg_wr_idx  = 3'($urandom_range(0, 7));
      cfg_wr_sel  = 2'($urandom_range(0, 2));
      cfg_wr_data = 33'({1'($urandom_range(0, 1)), $urandom});
      cfg_commit  = ($urandom_range(0, 9) == 0);
      nreq = ($urandom_range(0, 4) == 0) ? ~setup_request : setup_request;
      if (cfg_wr_en && !cfg_commit && nreq && !setup_request) nreq = 1'b0;
      setup_request = nreq;
      tick();
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
